// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code types and constants for the voice scheduler.
// Holds the prefix FSM state enum, the prefix bytes, the ignored-byte list and the key type.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } prefix_state_t;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;

   localparam int NUM_IGNORED = 7;
   localparam logic [NUM_IGNORED*8-1:0] IGNORED_BYTES =
      {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

   typedef struct packed {
      logic       ext;
      logic [7:0] code;
   } key_t;

   function automatic logic is_ignored(input logic [7:0] b);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_IGNORED; i++) begin
         if (IGNORED_BYTES[8*i +: 8] == b) r = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Prefix FSM turning raw PS/2 bytes into registered key make/break events.
// Latency 1 cycle byte->pend; no backpressure, accepts a byte every cycle.
module ps2_scan_decoder
   import ps2_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] i_scan_byte,
   input  logic       i_scan_valid,
   output logic       o_pend_vld,
   output key_t       o_pend_key,
   output logic       o_pend_make
);

   prefix_state_t r_state;
   prefix_state_t w_next;
   logic          w_emit;
   logic          w_make;
   logic          w_ext;

   always_comb begin
      w_next = r_state;
      w_emit = 1'b0;
      w_make = 1'b0;
      w_ext  = 1'b0;
      if (i_scan_valid && !is_ignored(i_scan_byte)) begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_scan_byte == BREAK_PREFIX)    w_next = ST_BRK;
               else if (i_scan_byte == EXT_PREFIX) w_next = ST_EXT;
               else begin
                  w_emit = 1'b1;
                  w_make = 1'b1;
               end
            end
            ST_EXT: begin
               if (i_scan_byte == BREAK_PREFIX) w_next = ST_EXT_BRK;
               else begin
                  w_emit = 1'b1;
                  w_make = 1'b1;
                  w_ext  = 1'b1;
                  w_next = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_emit = 1'b1;
               w_next = ST_IDLE;
            end
            ST_EXT_BRK: begin
               w_emit = 1'b1;
               w_ext  = 1'b1;
               w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state     <= ST_IDLE;
         o_pend_vld  <= 1'b0;
         o_pend_key  <= '0;
         o_pend_make <= 1'b0;
      end else begin
         r_state    <= w_next;
         o_pend_vld <= w_emit;
         if (w_emit) begin
            o_pend_key  <= '{ext: w_ext, code: i_scan_byte};
            o_pend_make <= w_make;
         end
      end
   end

endmodule

// File: rtl/ps2_voice_scheduler.sv
// Decodes PS/2 key events and shares NUM_VOICES voices among held keys (optional VOICE_STEAL_EN).
// Latency 2 cycles final byte->evt_valid; no backpressure, a byte may arrive every cycle.
module ps2_voice_scheduler
   import ps2_pkg::*;
#(
   parameter int NUM_VOICES = 4
)(
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [7:0]                    scan_byte,
   input  logic                          scan_valid,
   output logic [9*NUM_VOICES-1:0]       voice_key,
   output logic [NUM_VOICES-1:0]         voice_active,
   output logic                          evt_valid,
   output logic                          evt_on,
   output logic [$clog2(NUM_VOICES)-1:0] evt_voice,
   output logic [8:0]                    evt_key,
   output logic                          overflow,
   output logic                          all_busy
);

   localparam int VW = $clog2(NUM_VOICES);
   localparam logic [VW-1:0] RANK_ONE = VW'(1);

   logic          w_pend_vld;
   key_t          w_pend_key;
   logic          w_pend_make;

   key_t          r_key  [NUM_VOICES];
   logic [VW-1:0] r_rank [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_active;

   logic          w_hit;
   logic [VW-1:0] w_hit_idx;
   logic          w_free;
   logic [VW-1:0] w_free_idx;

   ps2_scan_decoder u_decoder (
      .Clk          (Clk),
      .Reset        (Reset),
      .i_scan_byte  (scan_byte),
      .i_scan_valid (scan_valid),
      .o_pend_vld   (w_pend_vld),
      .o_pend_key   (w_pend_key),
      .o_pend_make  (w_pend_make)
   );

   // Descending scan so the lowest matching index wins.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_VOICES-1; i >= 0; i--) begin
         if (r_active[i] && r_key[i] == w_pend_key) begin
            w_hit     = 1'b1;
            w_hit_idx = VW'(i);
         end
         if (!r_active[i]) begin
            w_free     = 1'b1;
            w_free_idx = VW'(i);
         end
      end
   end

`ifdef VOICE_STEAL_EN
   // With every voice busy the ranks are a permutation, so exactly one is the oldest.
   logic [VW-1:0] w_old_idx;
   always_comb begin
      w_old_idx = '0;
      for (int i = NUM_VOICES-1; i >= 0; i--) begin
         if (r_rank[i] == VW'(NUM_VOICES-1)) w_old_idx = VW'(i);
      end
   end
`endif

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_active  <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_key[i]  <= '0;
            r_rank[i] <= '0;
         end
         evt_valid <= 1'b0;
         evt_on    <= 1'b0;
         evt_voice <= '0;
         evt_key   <= '0;
         overflow  <= 1'b0;
      end else begin
         evt_valid <= 1'b0;
         overflow  <= 1'b0;
         if (w_pend_vld) begin
            if (w_pend_make) begin
               if (!w_hit) begin
                  if (w_free) begin
                     for (int i = 0; i < NUM_VOICES; i++) begin
                        if (r_active[i]) r_rank[i] <= r_rank[i] + RANK_ONE;
                     end
                     r_active[w_free_idx] <= 1'b1;
                     r_key[w_free_idx]    <= w_pend_key;
                     r_rank[w_free_idx]   <= '0;
                     evt_valid <= 1'b1;
                     evt_on    <= 1'b1;
                     evt_voice <= w_free_idx;
                     evt_key   <= w_pend_key;
                  end else begin
                     overflow <= 1'b1;
`ifdef VOICE_STEAL_EN
                     for (int i = 0; i < NUM_VOICES; i++) begin
                        if (r_rank[i] < r_rank[w_old_idx]) r_rank[i] <= r_rank[i] + RANK_ONE;
                     end
                     r_key[w_old_idx]  <= w_pend_key;
                     r_rank[w_old_idx] <= '0;
                     evt_valid <= 1'b1;
                     evt_on    <= 1'b1;
                     evt_voice <= w_old_idx;
                     evt_key   <= w_pend_key;
`endif
                  end
               end
            end else if (w_hit) begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (r_active[i] && r_rank[i] > r_rank[w_hit_idx]) r_rank[i] <= r_rank[i] - RANK_ONE;
               end
               r_active[w_hit_idx] <= 1'b0;
               r_rank[w_hit_idx]   <= '0;
               evt_valid <= 1'b1;
               evt_on    <= 1'b0;
               evt_voice <= w_hit_idx;
               evt_key   <= w_pend_key;
            end
         end
      end
   end

   always_comb begin
      voice_key = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_key[9*i +: 9] = r_key[i];
      end
   end

   assign voice_active = r_active;
   assign all_busy     = &r_active;

endmodule
